adjust_arbiter: RTL



---
 rtl/adjust_pkg.sv | 14 +
 rtl/adjust_unit.sv | 25 ++
 rtl/adjust_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/adjust_pkg.sv
// Shared types and default constants for the threshold-adjust arbiter slice.
package adjust_pkg;
  localparam int ADJ_DATA_W = 8;
  localparam int ADJ_THRESH = 50;
  localparam int ADJ_HI_SUB = 10;
  localparam int ADJ_LO_ADD = 20;

  typedef logic [ADJ_DATA_W-1:0] adj_data_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;
endpackage

// File: rtl/adjust_unit.sv
// Combinational threshold adjust: values above THRESH drop by HI_SUB, others rise by LO_ADD.
module adjust_unit
  import adjust_pkg::*;
#(
  parameter int DATA_W = ADJ_DATA_W,
  parameter int THRESH = ADJ_THRESH,
  parameter int HI_SUB = ADJ_HI_SUB,
  parameter int LO_ADD = ADJ_LO_ADD
) (
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam logic [31:0] THRESH_U = 32'(THRESH);

  // Unsigned compare, result wraps modulo 2^DATA_W
  always_comb begin
    if (32'(x) > THRESH_U) begin
      y = x - DATA_W'(HI_SUB);
    end else begin
      y = x + DATA_W'(LO_ADD);
    end
  end

endmodule

// File: rtl/adjust_arbiter.sv
// Round-robin sharing of one adjust datapath among NUM_REQ requesters,
// with a single registered output stage tagged by requester index.
module adjust_arbiter
  import adjust_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = ADJ_DATA_W,
  parameter int THRESH  = ADJ_THRESH,
  parameter int HI_SUB  = ADJ_HI_SUB,
  parameter int LO_ADD  = ADJ_LO_ADD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  input  logic                        rsp_ready,
  output logic [15:0]                 served_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      k;
    logic [ID_W:0]        sum;
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = rot[i] ? ID_W'(i) : k;
    end
    sum = {1'b0, k} + {1'b0, ptr};
    sum = (sum >= NUM_REQ_X) ? (sum - NUM_REQ_X) : sum;
    return sum[ID_W-1:0];
  endfunction

  stage_state_e        state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [15:0]         served_cnt_r;

  logic [ID_W-1:0]     grant_id_s;
  logic                can_accept_s;
  logic                xfer_s;
  logic                rsp_done_s;
  logic [DATA_W-1:0]   adj_in_s;
  logic [DATA_W-1:0]   adj_out_s;

  // Grant selection; req_ready is held low while reset is asserted
  always_comb begin
    grant_id_s   = rr_pick(req_valid, rr_ptr_r);
    can_accept_s = rst_n && ((state_r == ST_EMPTY) || rsp_ready);
    xfer_s       = can_accept_s && (|req_valid);
    rsp_done_s   = (state_r == ST_FULL) && rsp_ready;
    req_ready    = '0;
    if (xfer_s) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign adj_in_s = req_data[grant_id_s*DATA_W +: DATA_W];

  adjust_unit #(
    .DATA_W (DATA_W),
    .THRESH (THRESH),
    .HI_SUB (HI_SUB),
    .LO_ADD (LO_ADD)
  ) u_adjust (
    .x (adj_in_s),
    .y (adj_out_s)
  );

  // Output stage FSM, pointer advance and saturating completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_EMPTY;
      rr_ptr_r     <= '0;
      rsp_data_r   <= '0;
      rsp_id_r     <= '0;
      served_cnt_r <= 16'd0;
    end else begin
      if (rsp_done_s && (served_cnt_r != 16'hFFFF)) begin
        served_cnt_r <= served_cnt_r + 16'd1;
      end
      if (xfer_s) begin
        rsp_data_r <= adj_out_s;
        rsp_id_r   <= grant_id_s;
        rr_ptr_r   <= (grant_id_s == LAST_ID) ? '0 : (grant_id_s + ID_W'(1));
      end
      case (state_r)
        ST_EMPTY: begin
          if (xfer_s) state_r <= ST_FULL;
        end
        ST_FULL: begin
          if (rsp_ready && !xfer_s) state_r <= ST_EMPTY;
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_valid  = (state_r == ST_FULL);
  assign rsp_data   = rsp_data_r;
  assign rsp_id     = rsp_id_r;
  assign served_cnt = served_cnt_r;

endmodule
